// File: rtl/kgp_pkg.sv
// Shared definitions for the register-file write-back slice.
// Contents:
//   DATA_W, ADDR_W, LINK_REG : default register width, index width, link register
//   req_t                    : identifies which producer owns the write port
package kgp_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LINK_REG = 31;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_LINK,
        REQ_ALU,
        REQ_LD
    } req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// One bit per register marks a destination with an outstanding write.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   set_en, set_addr     : decode claims a destination
//   clr_en, clr_addr     : write-back commits a destination
//   rs_addr, rt_addr     : source lookups
//   rs_pending, rt_pending : lookup results (index 0 always 0)
module regfile_scoreboard
    import kgp_pkg::*;
#(
    parameter int unsigned ADDR_W = kgp_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_pending,
    output logic              rt_pending
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != '0)) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en && (clr_addr != '0)) begin
            clr_mask[clr_addr] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a fresh claim outlives a
    // same-cycle write of an older producer to the same register.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign rs_pending = (rs_addr != '0) && busy[rs_addr];
    assign rt_pending = (rt_addr != '0) && busy[rt_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Link writes win outright; ALU and load alternate when both request.
// The granted request is registered onto wr_en/wr_addr/wr_data for one cycle.
// Optional macro WB_FORWARD_EN adds a bypass from the registered write stage
// (rs_fwd, rt_fwd, fwd_data) and masks the matching busy flag.
// Ports:
//   clock, reset                          : clock, synchronous active-high reset
//   alu_valid/ready/addr/data             : ALU result producer
//   ld_valid/ready/addr/data              : load result producer
//   link_valid/ready/data                 : link write producer (to LINK_REG)
//   wr_en, wr_addr, wr_data               : registered register-file write
//   claim_valid, claim_addr               : decode destination claim
//   rs_addr, rt_addr, rs_busy, rt_busy    : hazard lookup
//   rs_fwd, rt_fwd, fwd_data              : bypass (WB_FORWARD_EN only)
module regfile_wb_arbiter
    import kgp_pkg::*;
#(
    parameter int unsigned DATA_W   = kgp_pkg::DATA_W,
    parameter int unsigned ADDR_W   = kgp_pkg::ADDR_W,
    parameter int unsigned LINK_REG = kgp_pkg::LINK_REG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              link_valid,
    output logic              link_ready,
    input  logic [DATA_W-1:0] link_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
`ifdef WB_FORWARD_EN
    output logic              rs_fwd,
    output logic              rt_fwd,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              rs_busy,
    output logic              rt_busy
);

    req_t              grant;
    logic              rr_ld;      // 1: load wins the next contended cycle
    logic              contended;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              commit;
    logic              rs_pending;
    logic              rt_pending;

    assign contended = alu_valid && ld_valid && !link_valid;

    always_comb begin
        grant = REQ_NONE;
        if (!reset) begin
            if (link_valid) begin
                grant = REQ_LINK;
            end else if (contended) begin
                grant = rr_ld ? REQ_LD : REQ_ALU;
            end else if (alu_valid) begin
                grant = REQ_ALU;
            end else if (ld_valid) begin
                grant = REQ_LD;
            end
        end
    end

    assign link_ready = (grant == REQ_LINK);
    assign alu_ready  = (grant == REQ_ALU);
    assign ld_ready   = (grant == REQ_LD);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (grant)
            REQ_LINK: begin
                sel_addr = ADDR_W'(LINK_REG);
                sel_data = link_data;
            end
            REQ_ALU: begin
                sel_addr = alu_addr;
                sel_data = alu_data;
            end
            REQ_LD: begin
                sel_addr = ld_addr;
                sel_data = ld_data;
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
    end

    // Writes to the zero register are accepted but never reach the file.
    assign commit = (grant != REQ_NONE) && (sel_addr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ld <= 1'b0;
        end else if (contended) begin
            rr_ld <= ~rr_ld;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= commit;
            if (commit) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (claim_valid),
        .set_addr  (claim_addr),
        .clr_en    (commit),
        .clr_addr  (sel_addr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_pending(rs_pending),
        .rt_pending(rt_pending)
    );

`ifdef WB_FORWARD_EN
    // wr_en is never set for address 0, so no explicit zero check is needed.
    assign rs_fwd   = wr_en && (wr_addr == rs_addr);
    assign rt_fwd   = wr_en && (wr_addr == rt_addr);
    assign fwd_data = wr_data;
    assign rs_busy  = rs_pending && !rs_fwd;
    assign rt_busy  = rt_pending && !rt_fwd;
`else
    assign rs_busy  = rs_pending;
    assign rt_busy  = rt_pending;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x32 register file's single write port.
- Three producers share the port: ALU result, load result and link write (jal-style return address into r31).
- Each producer uses a valid/ready handshake.
- The block drives a registered write command (enable, address, data) into the register file.
- It tracks in-flight destination registers so decode can detect RAW hazards.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register index width (2**ADDR_W registers)
LINK_REG, 31, destination index for link writes

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
alu_valid  in  1  ALU result available
alu_ready  out  1  ALU result accepted this cycle
alu_addr  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load result available
ld_ready  out  1  load result accepted
ld_addr  in  ADDR_W  load destination
ld_data  in  DATA_W  load data
link_valid  in  1  link write request
link_ready  out  1  link accepted
link_data  in  DATA_W  return address
wr_en  out  1  register file write enable
wr_addr  out  ADDR_W  register file write index
wr_data  out  DATA_W  register file write data
claim_valid  in  1  decode issues instruction with destination
claim_addr  in  ADDR_W  destination being claimed
rs_addr  in  ADDR_W  decode source 1
rt_addr  in  ADDR_W  decode source 2
rs_busy  out  1  rs has pending write
rt_busy  out  1  rt has pending write

Behaviour:
- Interface: reset is named reset and is synchronous, active-high; the clock is named clock.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - Scoreboard cleared to all 0.
  - Round-robin pointer favours ALU.
  - All ready outputs are 0 while reset is high.
- Arbitration (combinational grant, one per cycle):
  - link_valid has absolute priority.
  - Otherwise ALU and load alternate round-robin when both are valid.
  - The pointer toggles only when a round-robin grant is taken.
- Ready rule: x_ready = grant to x. The register file never back-pressures, so an unopposed requester is accepted in the same cycle it asserts valid.
- Handshake rules:
  - Producers hold addr/data stable while valid && !ready.
  - valid must not drop before ready.
- Latency: an accepted request appears on wr_en/wr_addr/wr_data on the next clock edge, for exactly one cycle.
  - With no grant, wr_en=0 and wr_addr/wr_data hold their previous values.
- Link writes use wr_addr=LINK_REG.
- Address 0 (zero register):
  - The request is accepted (ready=1) but wr_en stays 0.
  - The scoreboard is not touched.
- Scoreboard (2**ADDR_W bits):
  - claim_valid with claim_addr!=0 sets bit[claim_addr].
  - An accepted write to addr clears bit[addr] at the grant edge.
  - Claim and clear on the same address in the same cycle: set wins (a newer producer is outstanding).
  - Link claims use claim_addr=LINK_REG.
- Hazard outputs: rs_busy = bit[rs_addr], rt_busy = bit[rt_addr]. Both are combinational from the registered scoreboard; index 0 always returns 0.
- Reset mid-operation: in-flight grants are discarded and no write is issued on the cycle after reset.

Optional Feature:
- Macro: WB_FORWARD_EN.
- With the macro:
  - Adds outputs rs_fwd (1), rt_fwd (1) and fwd_data (DATA_W).
  - When the registered write stage has wr_en=1 and wr_addr equals rs_addr (resp. rt_addr), x_fwd=1 and fwd_data=wr_data.
  - The matching x_busy is forced to 0, since the value is available via the bypass.
  - If both rs and rt match, both are asserted with the same data.
- Without the macro: these ports are absent and busy follows the scoreboard only.

Decomposition:
- Shared package (kgp_pkg):
  - DATA_W, ADDR_W and LINK_REG constants.
  - Requester enum {REQ_NONE, REQ_LINK, REQ_ALU, REQ_LD}.
- One natural sub-module: regfile_scoreboard, containing the busy bit vector, set/clear logic and the two lookups.
- Arbitration and the output register stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF -> alu_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- ALU and load both valid for 4 cycles (addr 3 and 4) -> grants alternate ALU, LD, ALU, LD; wr_addr sequence 3, 4, 3, 4.
- link_valid with ALU and load both valid, link_data=0x40 -> link granted first with wr_addr=31, wr_data=0x40; round-robin pointer unchanged.
- claim_addr=7, then rs_addr=7 -> rs_busy=1 until the ALU write to 7 is accepted, then 0 from the next cycle; a simultaneous claim and write to 7 leaves rs_busy=1.
- Load to addr 0 with ld_data=0x1234 -> ld_ready=1, wr_en stays 0, rs_busy for 0 stays 0.
- With WB_FORWARD_EN: write to 9 with data 0x55 in the output stage and rs_addr=rt_addr=9 -> rs_fwd=rt_fwd=1, fwd_data=0x55, rs_busy=0.
